// File: rtl/objram_arbiter.sv
// objram_arbiter: round-robin arbiter for the object-RAM write port, with grants
// allowed only inside a fixed window that opens on each falling edge of iVS.
module objram_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_W     = 3,
  parameter int DATA_W     = 13,
  parameter int WIN_CYCLES = 64
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        iVS,
  input  logic [NUM_REQ-1:0]          iReq,
  input  logic [NUM_REQ*ADDR_W-1:0]   iAddr,
  input  logic [NUM_REQ*DATA_W-1:0]   iData,
  output logic [NUM_REQ-1:0]          oGnt,
  output logic [ADDR_W-1:0]           oObjRam_addr,
  output logic [DATA_W-1:0]           oObjRam_data,
  output logic                        oObjRam_we,
  output logic                        oWinOpen,
  output logic                        oOverrun
);
  localparam int PW = $clog2(NUM_REQ);
  typedef enum logic {IDLE, WRITE} state_t;
  state_t          r_state;
  logic            r_last_vs;
  logic            r_win_open_d;
  logic [7:0]      r_win_cnt;
  logic [PW-1:0]   r_ptr;
  logic [7:0]      w_cnt_nxt;
  logic [PW-1:0]   w_sel;
  logic            w_frame_syn;
  assign w_frame_syn = r_last_vs & ~iVS;
  assign w_cnt_nxt   = w_frame_syn ? 8'(WIN_CYCLES) :
                       (r_win_cnt != 8'd0) ? r_win_cnt - 8'd1 : r_win_cnt;
  // Scan downward so the index closest to ptr+1 is the one left standing.
  always_comb begin
    w_sel = r_ptr;
    for (int i = NUM_REQ; i >= 1; i--)
      if (iReq[(int'(r_ptr) + i) % NUM_REQ]) w_sel = PW'((int'(r_ptr) + i) % NUM_REQ);
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_last_vs    <= 1'b0;
      r_win_open_d <= 1'b0;
      r_win_cnt    <= 8'd0;
      r_ptr        <= PW'(NUM_REQ - 1);
      oGnt         <= '0;
      oObjRam_addr <= '0;
      oObjRam_data <= '0;
      oObjRam_we   <= 1'b0;
      oWinOpen     <= 1'b0;
      oOverrun     <= 1'b0;
    end else begin
      r_last_vs    <= iVS;
      r_win_cnt    <= w_cnt_nxt;
      oWinOpen     <= w_cnt_nxt != 8'd0;
      r_win_open_d <= oWinOpen;
      if (r_win_cnt == 8'd0 && r_win_open_d && |(iReq & ~oGnt)) oOverrun <= 1'b1;
      if (r_state == IDLE) begin
        if (r_win_cnt != 8'd0 && |iReq) begin
          r_state      <= WRITE;
          r_ptr        <= w_sel;
          oGnt         <= NUM_REQ'(1) << w_sel;
          oObjRam_we   <= 1'b1;
          oObjRam_addr <= iAddr[int'(w_sel)*ADDR_W +: ADDR_W];
          oObjRam_data <= iData[int'(w_sel)*DATA_W +: DATA_W];
        end
      end else begin
        r_state    <= IDLE;
        oGnt       <= '0;
        oObjRam_we <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_objram_arbiter.sv
// tb_objram_arbiter: directed checks of windowing, round robin, reset and overrun,
// with writes checked against a scoreboard queue filled as stimulus is driven.
module tb_objram_arbiter;
  typedef struct packed {
    logic [3:0]  gnt;
    logic [2:0]  addr;
    logic [12:0] data;
  } txn_t;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        vs_a, vs_b;
  logic [3:0]  req_a, req_b;
  logic [11:0] addr_bus;
  logic [51:0] data_bus;
  logic [3:0]  gnt_a, gnt_b;
  logic [2:0]  ra_a, ra_b;
  logic [12:0] rd_a, rd_b;
  logic        we_a, we_b, win_a, win_b, ovr_a, ovr_b;
  logic [2:0]  a_k [4] = '{3'd6, 3'd1, 3'd5, 3'd3};
  logic [12:0] d_k [4] = '{13'h0F0, 13'h055, 13'h1A3, 13'h1FFF};
  txn_t        qa[$];
  logic [3:0]  qb[$];
  txn_t        e_a;
  logic [3:0]  e_b;
  int          total = 0, bad = 0, n_we_a = 0, n_we_b = 0;
  always #5 clk = ~clk;
  objram_arbiter u_a (
    .clk(clk), .reset_n(reset_n), .iVS(vs_a), .iReq(req_a), .iAddr(addr_bus), .iData(data_bus),
    .oGnt(gnt_a), .oObjRam_addr(ra_a), .oObjRam_data(rd_a), .oObjRam_we(we_a),
    .oWinOpen(win_a), .oOverrun(ovr_a));
  objram_arbiter #(.WIN_CYCLES(4)) u_b (
    .clk(clk), .reset_n(reset_n), .iVS(vs_b), .iReq(req_b), .iAddr(addr_bus), .iData(data_bus),
    .oGnt(gnt_b), .oObjRam_addr(ra_b), .oObjRam_data(rd_b), .oObjRam_we(we_b),
    .oWinOpen(win_b), .oOverrun(ovr_b));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic void push_a(input int k);
    txn_t t;
    t.gnt  = 4'b0001 << k;
    t.addr = a_k[k];
    t.data = d_k[k];
    qa.push_back(t);
  endfunction
  // Raise iVS now, lower it after the next edge; returns #1 after edge e.
  task automatic vs_fall(input bit b);
    if (b) vs_b = 1'b1; else vs_a = 1'b1;
    @(posedge clk); #1;
    if (b) vs_b = 1'b0; else vs_a = 1'b0;
    @(posedge clk); #1;
  endtask
  always @(negedge clk) if (reset_n === 1'b1) begin
    if (we_a) begin
      n_we_a++;
      chk("unexpected_write_a", qa.size() != 0, 1);
      if (qa.size() != 0) begin
        e_a = qa.pop_front();
        chk("sb_gnt_a", gnt_a, e_a.gnt);
        chk("sb_addr_a", ra_a, e_a.addr);
        chk("sb_data_a", rd_a, e_a.data);
      end
    end
    if (we_b) begin
      n_we_b++;
      chk("unexpected_write_b", qb.size() != 0, 1);
      if (qb.size() != 0) begin
        e_b = qb.pop_front();
        chk("sb_gnt_b", gnt_b, e_b);
      end
    end
  end
  initial begin
    int base, lows, n;
    reset_n  = 1'b0;
    vs_a = 1'b0; vs_b = 1'b0; req_a = '0; req_b = '0;
    addr_bus = {a_k[3], a_k[2], a_k[1], a_k[0]};
    data_bus = {d_k[3], d_k[2], d_k[1], d_k[0]};
    repeat (2) @(posedge clk); #1;
    chk("rst_gnt", gnt_a, 0);
    chk("rst_we", we_a, 0);
    chk("rst_addr", ra_a, 0);
    chk("rst_data", rd_a, 0);
    chk("rst_win", win_a, 0);
    chk("rst_ovr", ovr_a, 0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    req_a = 4'b0001;
    repeat (5) @(posedge clk); #1;
    chk("gate_closed_no_write", n_we_a, 0);
    push_a(0);
    vs_fall(0);
    chk("gate_win_at_e", win_a, 1);
    chk("gate_no_gnt_at_e", gnt_a, 0);
    @(posedge clk); #1;
    chk("gate_gnt_e1", gnt_a, 4'b0001);
    req_a = '0;
    n = 0;
    while (win_a && n < 200) begin @(posedge clk); #1; n++; end
    chk("win_closed", win_a, 0);
    req_a = 4'b0100;
    push_a(2);
    vs_fall(0);
    @(posedge clk); #1;
    chk("single_gnt", gnt_a, 4'b0100);
    chk("single_we", we_a, 1);
    chk("single_addr", ra_a, 3'd5);
    chk("single_data", rd_a, 13'h1A3);
    req_a = '0;
    @(posedge clk); #1;
    chk("single_pulse_end", we_a, 0);
    repeat (7) @(posedge clk); #1;
    vs_fall(0);
    chk("restart_win_e2", win_a, 1);
    lows = 0;
    repeat (63) begin @(posedge clk); #1; if (!win_a) lows++; end
    chk("restart_continuous", lows, 0);
    @(posedge clk); #1;
    chk("restart_close", win_a, 0);
    req_a = 4'b1111;
    vs_fall(0);
    @(posedge clk); #1;
    chk("midwrite_gnt", gnt_a, 4'b1000);
    #1 reset_n = 1'b0;
    #1;
    chk("midrst_gnt", gnt_a, 0);
    chk("midrst_we", we_a, 0);
    chk("midrst_addr", ra_a, 0);
    chk("midrst_data", rd_a, 0);
    chk("midrst_win", win_a, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    for (int i = 0; i < 32; i++) push_a(i % 4);
    base = n_we_a;
    vs_fall(0);
    repeat (66) @(posedge clk); #1;
    chk("rr_queue_drained", qa.size(), 0);
    chk("rr_write_count", n_we_a - base, 32);
    req_a = '0;
    req_b = 4'b1111;
    qb.push_back(4'b0001);
    qb.push_back(4'b0010);
    vs_fall(1);
    chk("ovr_open", ovr_b, 0);
    repeat (4) @(posedge clk); #1;
    chk("ovr_win_closed", win_b, 0);
    chk("ovr_not_yet", ovr_b, 0);
    @(posedge clk); #1;
    chk("ovr_set", ovr_b, 1);
    qb.push_back(4'b0100);
    qb.push_back(4'b1000);
    vs_fall(1);
    repeat (6) @(posedge clk); #1;
    chk("ovr_sticky", ovr_b, 1);
    chk("ovr_queue_drained", qb.size(), 0);
    chk("ovr_write_count", n_we_b, 4);
    req_b = '0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/objram_arbiter.md
# objram_arbiter

Per-frame write scheduler and round-robin arbiter for the 8-entry object RAM. It lets several object-update requesters (bomb men, sprites, bombs) share the single object-RAM write port. Writes are issued only inside a fixed window that opens on the falling edge of iVS, so the renderer never sees a half-updated frame. The block sits between the game-logic trackers and the object RAM write port.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- ADDR_W, 3, object RAM address width
- DATA_W, 13, object RAM data width; format {on, tile[2:0], x[4:0], y[3:0]} is opaque to this block
- WIN_CYCLES, 64, write-window length in clk cycles (1..255)
- clk  in  1  clock
- reset_n  in  1  reset, asynchronous, active-low
- iVS  in  1  vertical sync from the display timing generator
- iReq  in  NUM_REQ  per-requester write request; level-held until granted
- iAddr  in  NUM_REQ*ADDR_W  requester k address at bits [k*ADDR_W +: ADDR_W]
- iData  in  NUM_REQ*DATA_W  requester k data at bits [k*DATA_W +: DATA_W]
- oGnt  out  NUM_REQ  one-hot grant pulse, 1 cycle
- oObjRam_addr  out  ADDR_W  object RAM write address
- oObjRam_data  out  DATA_W  object RAM write data
- oObjRam_we  out  1  object RAM write enable
- oWinOpen  out  1  write window open
- oOverrun  out  1  sticky: the window closed with an ungranted request pending

## Operation
- Frame sync: lastVS is a register (reset 0). frameSyn = lastVS & ~iVS.
- Window counter winCnt (8 bits, reset 0):
  - frameSyn loads WIN_CYCLES.
  - Otherwise winCnt decrements while nonzero.
  - oWinOpen = (winCnt != 0), registered.
  - A frameSyn while the window is open reloads the counter and restarts the window.
- FSM states, reset to IDLE:
  - IDLE: at an edge where winCnt != 0 and |iReq, select requester k and go to WRITE. In the same edge, register oGnt = 1<<k, oObjRam_we = 1, oObjRam_addr = iAddr[k], oObjRam_data = iData[k], and set ptr <= k.
  - WRITE: go to IDLE unconditionally. Clear oGnt and oObjRam_we.
- Round-robin selection: the first requesting index starting at (ptr+1) mod NUM_REQ and wrapping. ptr resets to NUM_REQ-1, so requester 0 has first priority after reset.
- Requester protocol:
  - Hold iReq, iAddr and iData stable until oGnt[k] is seen high.
  - Drop iReq at the next edge, or keep it high to request another write.
  - The IDLE cycle after WRITE guarantees a dropped request is never granted twice.
- oObjRam_addr and oObjRam_data hold their last values outside WRITE.
- Window closing during WRITE: the write completes normally. No new grant is issued while winCnt == 0.
- Overrun: winOpenD is oWinOpen delayed by one cycle. At the first edge with winCnt == 0 and winOpenD == 1, if |(iReq & ~oGnt), set oOverrun. It stays set until reset.
- Reset, asynchronous and effective immediately, including mid-write: oGnt = 0, oObjRam_we = 0, oObjRam_addr = 0, oObjRam_data = 0, oWinOpen = 0, oOverrun = 0, winCnt = 0, FSM = IDLE, ptr = NUM_REQ-1, lastVS = 0.

## Timing
- iVS falls between edges e-1 and e:
  - frameSyn is high in the cycle before e.
  - winCnt = WIN_CYCLES and oWinOpen = 1 after edge e.
- Earliest grant is at edge e+1: oGnt and oObjRam_we are high for the cycle after e+1.
- Grants are allowed at edges e+1 .. e+WIN_CYCLES. oWinOpen falls after edge e+WIN_CYCLES.
- Throughput is at most one write per 2 cycles. With continuous requests, WIN_CYCLES = 64 gives exactly 32 writes per window, at edges e+1, e+3, ..., e+63.
- Grant-to-RAM latency is 0: oGnt, oObjRam_we, address and data are all valid in the same cycle.
- Request-to-grant worst case is 2*(NUM_REQ-1)+1 cycles inside an open window, given all other requesters saturating.

## Test plan
- Reset behaviour: reset_n low mid-WRITE → all outputs 0 in the same cycle. After release, first grant goes to requester 0 when iReq = 4'b1111.
- Single write: iReq = 4'b0100, iAddr[2] = 3'd5, iData[2] = 13'h1A3, iVS falls before edge e → at edge e+1, oGnt = 4'b0100, oObjRam_we = 1, addr = 5, data = 13'h1A3 for one cycle. No second grant after the requester drops iReq.
- Round robin: iReq = 4'b1111 held for the whole window → grant order 0,1,2,3,0,... and exactly 32 oObjRam_we pulses.
- Window gating: iReq = 4'b0001 asserted while oWinOpen = 0 → no grant until the next iVS falling edge, then a grant at e+1.
- Overrun: WIN_CYCLES = 4, iReq = 4'b1111 held → 2 grants (requesters 0 and 1), then oOverrun = 1 one edge after the window closes; it stays 1 through later frames.
- Restart: a second iVS fall at e+10 → winCnt reloads to WIN_CYCLES and oWinOpen stays high continuously.
